// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sync, detect and hold four request lines, then present
// a frozen, masked request vector to the priority encoder until acked.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  input  logic       ovf_clr,
  output logic [3:0] d,
  output logic       req,
  output logic [3:0] ovf
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0][3:0] chain;
  logic [3:0] s;
  logic [3:0] prev;
  logic [3:0] pend;
  logic [3:0] hit;
  logic [3:0] ret;
  logic [3:0] ovf_set;
  logic [3:0] live;

  assign s    = chain[SYNC_STAGES-1];
  assign live = pend & mask;

  always_comb begin
    hit = s;
    if (EDGE_MODE != 0) hit = s & ~prev;
  end

  // A retire only counts while a request is actually held.
  always_comb begin
    ret = '0;
    if (state == HOLD && ack) ret[ack_idx] = 1'b1;
  end

  always_comb begin
    ovf_set = '0;
    if (EDGE_MODE != 0) ovf_set = hit & pend & ~ret;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], irq};
      prev  <= s;
    end
  end

  // Set wins over retire and over ovf_clr on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ovf  <= '0;
    end else begin
      pend <= (pend & ~ret) | hit;
      ovf  <= (ovf_clr ? 4'h0 : ovf) | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      d     <= '0;
      req   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (live != 4'h0) begin
            d     <= live;
            req   <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            d     <= '0;
            req   <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          d     <= '0;
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: scoreboard of presented vectors plus direct checks
// on timing, freeze, overflow, reset and level capture.
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq, irq_l, mask;
  logic       ack, ack_l, ovf_clr;
  logic [1:0] ack_idx, ack_idx_l;
  logic [3:0] d, ovf, d_l, ovf_l;
  logic       req, req_l;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(1)) u_e (
    .clk(clk), .rst_n(rst_n), .irq(irq), .mask(mask),
    .ack(ack), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .d(d), .req(req), .ovf(ovf)
  );

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(0)) u_l (
    .clk(clk), .rst_n(rst_n), .irq(irq_l), .mask(mask),
    .ack(ack_l), .ack_idx(ack_idx_l), .ovf_clr(ovf_clr),
    .d(d_l), .req(req_l), .ovf(ovf_l)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input logic [1:0] idx);
    ack = 1'b1;
    ack_idx = idx;
    step(1);
    ack = 1'b0;
  endtask

  // Every req rising edge must match the next queued expected vector.
  always begin
    @(posedge clk);
    #1;
    if (req && !req_q) begin
      if (exp_q.size() == 0) chk("unexp_req", {28'h0, d}, 32'h0);
      else chk("present", {28'h0, d}, {28'h0, exp_q.pop_front()});
    end
    req_q = req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    irq = '0; irq_l = '0; mask = '0;
    ack = 1'b0; ack_l = 1'b0; ack_idx = '0; ack_idx_l = '0;
    ovf_clr = 1'b0;
    step(2);
    chk("rst_d", d, 0);
    chk("rst_req", req, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_d_l", d_l, 0);
    rst_n = 1'b1;
    mask = 4'hF;
    step(2);

    // single request, latency and GAP
    irq = 4'b0010;
    exp_q.push_back(4'b0010);
    step(3);
    chk("lat_e3_req", req, 0);
    step(1);
    chk("lat_e4_d", d, 4'b0010);
    chk("lat_e4_req", req, 1);
    step(2);
    chk("hold_d", d, 4'b0010);
    do_ack(2'd1);
    chk("gap_d", d, 0);
    chk("gap_req", req, 0);
    step(4);
    chk("idle_d", d, 0);
    irq = '0;
    step(3);

    // multiple lines
    irq = 4'b1010;
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0010);
    step(4);
    chk("multi_d", d, 4'b1010);
    do_ack(2'd3);
    chk("multi_gap", d, 0);
    step(1);
    chk("multi_idle", req, 0);
    step(1);
    chk("multi_d2", d, 4'b0010);
    do_ack(2'd1);
    step(3);
    chk("multi_done_d", d, 0);
    chk("multi_done_req", req, 0);
    irq = '0;
    step(3);

    // masking, ignored idle ack, freeze
    mask = 4'b0111;
    irq = 4'b1000;
    step(3);
    irq = '0;
    step(2);
    chk("mask_d", d, 0);
    chk("mask_req", req, 0);
    do_ack(2'd3);
    step(1);
    mask = 4'hF;
    exp_q.push_back(4'b1000);
    step(2);
    chk("unmask_d", d, 4'b1000);
    mask = 4'b0001;
    step(2);
    chk("freeze_d", d, 4'b1000);
    mask = 4'hF;
    do_ack(2'd3);
    step(3);
    chk("unmask_done", d, 0);

    // overflow
    irq = 4'b0001;
    exp_q.push_back(4'b0001);
    step(4);
    chk("ovf_d", d, 4'b0001);
    irq = '0;
    step(2);
    irq = 4'b0001;
    step(4);
    chk("ovf_set", ovf, 4'b0001);
    chk("ovf_hold_d", d, 4'b0001);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    irq = '0;
    step(2);
    irq = 4'b0001;
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, 4'b0001);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr2", ovf, 0);
    do_ack(2'd0);
    step(3);
    chk("ovf_done_d", d, 0);
    irq = '0;
    step(3);

    // simultaneous set and retire
    irq = 4'b0100;
    exp_q.push_back(4'b0100);
    step(4);
    chk("sim_d", d, 4'b0100);
    irq = '0;
    step(2);
    irq = 4'b0100;
    step(2);
    exp_q.push_back(4'b0100);
    do_ack(2'd2);
    chk("sim_ovf", ovf, 0);
    chk("sim_gap", d, 0);
    step(2);
    chk("sim_repr", d, 4'b0100);
    do_ack(2'd2);
    irq = '0;
    step(3);
    chk("sim_done", d, 0);

    // reset mid-HOLD, then held line captured as new edge
    irq = 4'b0010;
    exp_q.push_back(4'b0010);
    step(4);
    chk("prerst_d", d, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("arst_d", d, 0);
    chk("arst_req", req, 0);
    chk("arst_ovf", ovf, 0);
    irq = 4'b0001;
    step(1);
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    step(3);
    chk("rel_e3_req", req, 0);
    step(1);
    chk("rel_e4_d", d, 4'b0001);
    do_ack(2'd0);
    step(3);
    chk("rel_done", d, 0);
    irq = '0;

    // level mode
    irq_l = 4'b0001;
    step(4);
    chk("lvl_d", d_l, 4'b0001);
    chk("lvl_req", req_l, 1);
    ack_l = 1'b1;
    ack_idx_l = 2'd0;
    step(1);
    ack_l = 1'b0;
    chk("lvl_gap", d_l, 0);
    step(2);
    chk("lvl_repr", d_l, 4'b0001);
    chk("lvl_ovf", ovf_l, 0);
    irq_l = '0;
    step(2);

    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
